oled_frame_arbiter: RTL and testbench

OLED_FRAME_ARBITER -- requirements
Module: oled_frame_arbiter

---
 rtl/oled_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 16 +
 rtl/oled_frame_arbiter.sv | 146 ++++++++++++++
 tb/tb_oled_frame_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED frame arbiter: frame geometry, FSM states
// and the helper that slices one display row out of a packed frame.
package oled_pkg;

    localparam int ROW_W   = 128;
    localparam int ROWS    = 4;
    localparam int FRAME_W = ROW_W * ROWS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_LOAD,
        ST_START,
        ST_DRAIN,
        ST_ACK
    } state_t;

    // Row r occupies bits [r*ROW_W +: ROW_W]; row 0 sits in the low bits.
    function automatic logic [ROW_W-1:0] frame_row(input logic [FRAME_W-1:0] frame,
                                                  input int unsigned r);
        return frame[r*ROW_W +: ROW_W];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that was not granted
// last wins; a lone request always wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = pointer ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/oled_frame_arbiter.sv
// Arbitrates two frame producers onto one OLED driver: latches the winner's
// frame into the row registers, runs one refresh handshake, then acknowledges.
module oled_frame_arbiter
    import oled_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int TIMER_W        = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         req,
    input  logic [FRAME_W-1:0] frame0,
    input  logic [FRAME_W-1:0] frame1,
    input  logic               oled_done,
    output logic               oled_enable,
    output logic [ROW_W-1:0]   row0,
    output logic [ROW_W-1:0]   row1,
    output logic [ROW_W-1:0]   row2,
    output logic [ROW_W-1:0]   row3,
    output logic [1:0]         gnt,
    output logic               busy,
    output logic               err
);

    localparam logic [TIMER_W-1:0] WD_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t             state_reg, state_next;
    logic               sel_reg, sel_next;
    logic               last_reg, last_next;
    logic               err_reg, err_next;
    logic [TIMER_W-1:0] wd_reg, wd_next;
    logic               load_rows;
    logic               wd_expired;
    logic [1:0]         arb_grant;
    logic [FRAME_W-1:0] frame_sel;

    rr_arb2 u_rr_arb2 (
        .req     (req),
        .pointer (last_reg),
        .grant   (arb_grant)
    );

    assign wd_expired = (wd_reg == WD_LAST);
    assign frame_sel  = sel_reg ? frame1 : frame0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            sel_reg   <= 1'b0;
            last_reg  <= 1'b1;
            err_reg   <= 1'b0;
            wd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            last_reg  <= last_next;
            err_reg   <= err_next;
            wd_reg    <= wd_next;
        end
    end

    // The watchdog defaults to zero, so it restarts on every transition and
    // only advances while a waiting state is held.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        last_next  = last_reg;
        err_next   = err_reg;
        wd_next    = '0;
        load_rows  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    sel_next   = arb_grant[1];
                    state_next = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (oled_done) begin
                    state_next = ST_LOAD;
                end else if (wd_expired) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    wd_next = wd_reg + 1'b1;
                end
            end
            ST_LOAD: begin
                load_rows  = 1'b1;
                state_next = ST_START;
            end
            ST_START: begin
                if (!oled_done) begin
                    state_next = ST_DRAIN;
                end else if (wd_expired) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    wd_next = wd_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (oled_done) begin
                    state_next = ST_ACK;
                end else if (wd_expired) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    wd_next = wd_reg + 1'b1;
                end
            end
            ST_ACK: begin
                last_next  = sel_reg;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        oled_enable = !((state_reg == ST_START) || (state_reg == ST_DRAIN));
        busy        = (state_reg != ST_IDLE);
        gnt         = 2'b00;
        if (state_reg == ST_ACK) begin
            gnt = sel_reg ? 2'b10 : 2'b01;
        end
        err = err_reg;
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        logic [ROW_W-1:0] row_reg;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                row_reg <= '0;
            end else if (load_rows) begin
                row_reg <= frame_row(frame_sel, gi);
            end
        end
    end

    assign row0 = g_row[0].row_reg;
    assign row1 = g_row[1].row_reg;
    assign row2 = g_row[2].row_reg;
    assign row3 = g_row[3].row_reg;

endmodule

// File: tb/tb_oled_frame_arbiter.sv
// Self-checking bench for oled_frame_arbiter: a reactive transaction-level
// model is compared against the DUT every cycle, plus directed scenarios.
module tb_oled_frame_arbiter;

    localparam int TO = 16;
    localparam int FW = 512;
    localparam int RW = 128;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [FW-1:0] frame0 = '0;
    logic [FW-1:0] frame1 = '0;
    logic          oled_done = 1'b1;
    logic          oled_enable;
    logic [RW-1:0] row0, row1, row2, row3;
    logic [1:0]    gnt;
    logic          busy;
    logic          err;
    logic [FW-1:0] rows_all;

    assign rows_all = {row3, row2, row1, row0};

    always #5 clk = ~clk;

    oled_frame_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .TIMER_W        (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .frame0      (frame0),
        .frame1      (frame1),
        .oled_done   (oled_done),
        .oled_enable (oled_enable),
        .row0        (row0),
        .row1        (row1),
        .row2        (row2),
        .row3        (row3),
        .gnt         (gnt),
        .busy        (busy),
        .err         (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d, required %0d", name, $time, act, exp);
    endtask

    task automatic chk_wide(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h, required %h", name, $time, act, exp);
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    // Driver stand-in: ready (1) while idle, drops for a while once enable goes low.
    int done_mode = 0;   // 0 normal, 1 stuck low, 2 stuck high
    int low_len   = 3;
    bit rand_len  = 1'b0;
    int drv_cnt   = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            oled_done = 1'b1;
            drv_cnt   = 0;
        end else if (done_mode == 1) begin
            oled_done = 1'b0;
        end else if (done_mode == 2) begin
            oled_done = 1'b1;
        end else if (drv_cnt > 0) begin
            drv_cnt--;
            oled_done = (drv_cnt == 0);
        end else if (!oled_enable && oled_done) begin
            oled_done = 1'b0;
            if (rand_len) drv_cnt = ($urandom_range(0, 19) == 0) ? 20 : int'($urandom_range(1, 6));
            else drv_cnt = low_len;
        end else begin
            oled_done = 1'b1;
        end
    end

    // Reference model: a transaction thread that follows the frame-update
    // handshake step by step, reacting to the inputs seen at each rising edge.
    logic [FW-1:0] m_rows;
    logic          m_en, m_busy, m_err, m_last;
    logic [1:0]    m_gnt;
    bit            rst_flag = 1'b1;

    always @(negedge reset_n) rst_flag = 1'b1;

    function automatic bit aborted();
        return (!reset_n || rst_flag);
    endfunction

    task automatic m_clear();
        m_rows = '0; m_en = 1'b1; m_busy = 1'b0; m_err = 1'b0; m_gnt = 2'b00; m_last = 1'b1;
    endtask

    // res: 1 = value seen, 0 = watchdog expired, -1 = reset
    task automatic m_wait_done(input logic v, output int res);
        int k;
        k = 0;
        forever begin
            k++;
            @(posedge clk);
            if (aborted()) begin res = -1; return; end
            if (oled_done == v) begin res = 1; return; end
            if (k == TO) begin res = 0; return; end
        end
    endtask

    task automatic m_run();
        logic [1:0] r;
        logic       w;
        int         res;
        forever begin
            m_gnt = 2'b00; m_busy = 1'b0; m_en = 1'b1;
            @(posedge clk);
            if (aborted()) return;
            r = req;
            if (r == 2'b00) continue;
            w = (r == 2'b11) ? ~m_last : r[1];
            m_busy = 1'b1;
            m_wait_done(1'b1, res);
            if (res < 0) return;
            if (res == 0) begin m_err = 1'b1; continue; end
            @(posedge clk);
            if (aborted()) return;
            m_rows = w ? frame1 : frame0;
            m_en = 1'b0;
            m_wait_done(1'b0, res);
            if (res < 0) return;
            if (res == 0) begin m_err = 1'b1; continue; end
            m_wait_done(1'b1, res);
            if (res < 0) return;
            if (res == 0) begin m_err = 1'b1; continue; end
            m_en  = 1'b1;
            m_gnt = w ? 2'b10 : 2'b01;
            m_last = w;
            @(posedge clk);
            if (aborted()) return;
        end
    endtask

    initial begin
        forever begin
            m_clear();
            wait (reset_n === 1'b1);
            rst_flag = 1'b0;
            m_run();
        end
    end

    // Compare process: every cycle out of reset, plus gnt shape checks.
    logic [1:0] gnt_prev = 2'b00;
    int gnt_cnt0 = 0;
    int gnt_cnt1 = 0;

    always @(negedge clk) begin
        if (reset_n && !rst_flag) begin
            chk_wide("cyc_rows", rows_all, m_rows);
            chk_int("cyc_enable", int'(oled_enable), int'(m_en));
            chk_int("cyc_busy", int'(busy), int'(m_busy));
            chk_int("cyc_gnt", int'(gnt), int'(m_gnt));
            chk_int("cyc_err", int'(err), int'(m_err));
            if (gnt != 2'b00) begin
                chk_int("gnt_onehot", int'(gnt == 2'b11), 0);
                chk_int("gnt_single_cycle", int'(gnt_prev != 2'b00), 0);
                if (gnt[0]) gnt_cnt0++;
                if (gnt[1]) gnt_cnt1++;
                $display("txn @%0t: gnt=%b row0=%h err=%b", $time, gnt, row0, err);
            end
            gnt_prev = gnt;
        end else begin
            gnt_prev = 2'b00;
        end
    end

    task automatic wait_gnt(input int bound, output logic [1:0] g, output int cyc);
        g = 2'b00;
        cyc = 0;
        while (cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (gnt != 2'b00) begin g = gnt; return; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        req = 2'b00;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [1:0]    g;
        int            cyc, base, cnt;
        logic [FW-1:0] a5;

        a5 = {64{8'hA5}};
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk_wide("reset_rows", rows_all, '0);
        chk_int("reset_enable", int'(oled_enable), 1);
        chk_int("reset_gnt", int'(gnt), 0);
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_err", int'(err), 0);

        // Single request, all-0xA5 frame, driver low for 3 cycles.
        frame0 = a5; low_len = 3; base = gnt_cnt0;
        req = 2'b01;
        wait_gnt(60, g, cyc);
        req = 2'b00;
        chk_int("t1_gnt", int'(g), 1);
        chk_wide("t1_rows", rows_all, a5);
        repeat (10) @(negedge clk);
        chk_int("t1_gnt_once", gnt_cnt0 - base, 1);
        chk_int("t1_enable_back", int'(oled_enable), 1);

        // Minimum latency with a 1-cycle driver.
        low_len = 1; frame1 = rand_frame();
        req = 2'b10;
        wait_gnt(30, g, cyc);
        req = 2'b00;
        chk_int("lat_gnt", int'(g), 2);
        chk_int("lat_cycles", cyc, 5);
        chk_wide("lat_rows", rows_all, frame1);

        // Tie from reset: requester 0 first, then requester 1.
        do_reset();
        frame0 = rand_frame(); frame1 = rand_frame(); low_len = 3;
        req = 2'b11;
        wait_gnt(60, g, cyc);
        req = req & ~g;
        chk_int("t2_first_gnt", int'(g), 1);
        chk_wide("t2_first_rows", rows_all, frame0);
        wait_gnt(60, g, cyc);
        req = req & ~g;
        chk_int("t2_second_gnt", int'(g), 2);
        chk_wide("t2_second_rows", rows_all, frame1);
        req = 2'b00;
        repeat (5) @(negedge clk);

        // Driver never ready: watchdog fires after TO cycles in the wait.
        done_mode = 1;
        repeat (2) @(negedge clk);
        base = gnt_cnt0 + gnt_cnt1; cnt = 0;
        req = 2'b01;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (err) break;
            if (busy) cnt++;
        end
        req = 2'b00;
        chk_int("t3_err", int'(err), 1);
        chk_int("t3_wait_cycles", cnt, TO);
        chk_int("t3_busy_fell", int'(busy), 0);
        chk_int("t3_no_gnt", gnt_cnt0 + gnt_cnt1 - base, 0);
        repeat (5) @(negedge clk);
        chk_int("t3_err_sticky", int'(err), 1);
        done_mode = 0;
        do_reset();
        @(negedge clk);
        chk_int("t3_err_cleared", int'(err), 0);

        // Reset while draining, then a normal request from requester 1.
        low_len = 6; frame0 = rand_frame();
        base = gnt_cnt0 + gnt_cnt1; cnt = 0;
        req = 2'b01;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!oled_enable) begin cnt = 1; break; end
        end
        chk_int("t4_start_seen", cnt, 1);
        @(negedge clk);
        chk_int("t4_in_drain", int'(oled_enable), 0);
        #1 reset_n = 1'b0;
        req = 2'b00;
        @(negedge clk);
        chk_wide("t4_rst_rows", rows_all, '0);
        chk_int("t4_rst_enable", int'(oled_enable), 1);
        chk_int("t4_rst_gnt", int'(gnt), 0);
        chk_int("t4_rst_busy", int'(busy), 0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_int("t4_no_gnt", gnt_cnt0 + gnt_cnt1 - base, 0);
        frame1 = rand_frame(); low_len = 3;
        req = 2'b10;
        wait_gnt(60, g, cyc);
        req = 2'b00;
        chk_int("t4_after_gnt", int'(g), 2);
        chk_wide("t4_after_rows", rows_all, frame1);

        // Request dropped after one cycle still completes.
        repeat (3) @(negedge clk);
        frame0 = rand_frame();
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        wait_gnt(60, g, cyc);
        chk_int("t5_gnt", int'(g), 1);
        chk_wide("t5_rows", rows_all, frame0);

        // Random traffic against the model.
        rand_len = 1'b1;
        base = gnt_cnt0 + gnt_cnt1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (req[i] && gnt[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 5) == 0) begin
                    if (i == 0) frame0 = rand_frame();
                    else frame1 = rand_frame();
                    req[i] = 1'b1;
                end
            end
        end
        req = 2'b00;
        rand_len = 1'b0;
        repeat (40) @(negedge clk);
        chk_int("rand_some_gnts", int'((gnt_cnt0 + gnt_cnt1 - base) > 20), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
